// File: rtl/rst_seq.sv
// rst_seq: sequenced multi-domain reset generator with a debounced button,
// software and trap triggers. rev 1.0
`default_nettype none

module rst_seq #(
  parameter int unsigned N_DOM    = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HOLD     = 16'hFFFF,
  parameter int unsigned GAP      = 16,
  parameter int unsigned DEB_CYC  = 8,
  parameter bit          TRAP_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_rst,
  input  logic             sw_rst_req,
  input  logic             trap,
  output logic [N_DOM-1:0] dom_rst,
  output logic             rst_done,
  output logic [1:0]       rst_cause
);

  // Counters are loaded with N-1 and tested for zero before decrementing,
  // so the terminal edge lands exactly N edges after the load.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);
  localparam logic [7:0]       DEB_MAX = 8'(DEB_CYC);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_s1;
  logic             btn_s2;
  logic [7:0]       deb_cnt;
  logic             btn_trig;
  logic             run_trig;
  logic             accept;
  logic [N_DOM-1:0] next_dom;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      deb_cnt <= 8'd0;
    end else begin
      btn_s1 <= btn_rst;
      btn_s2 <= btn_s1;
      if (!btn_s2)
        deb_cnt <= 8'd0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign btn_trig = (deb_cnt == DEB_MAX);
  assign run_trig = (state == S_RUN) && (sw_rst_req || (TRAP_RST && trap));
  assign accept   = btn_trig || run_trig;
  // Shifting zeros in from the bottom releases domains strictly in ascending order.
  assign next_dom = dom_rst << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      cnt       <= HOLD_LD;
      dom_rst   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= 2'b00;
    end else if (accept) begin
      state     <= S_HOLD;
      cnt       <= HOLD_LD;
      dom_rst   <= '1;
      rst_done  <= 1'b0;
      if (btn_trig)
        rst_cause <= 2'b01;
      else if (TRAP_RST && trap)
        rst_cause <= 2'b10;
      else
        rst_cause <= 2'b11;
    end else begin
      case (state)
        S_HOLD, S_RELEASE: begin
          if (cnt == '0) begin
            dom_rst <= next_dom;
            cnt     <= GAP_LD;
            if (next_dom == '0) begin
              state    <= S_RUN;
              rst_done <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RUN: ;
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 3: number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: width of the hold/gap counter.
REQ-003 SHALL have parameter HOLD, default 16'hFFFF: cycles all domains stay in reset before the first release (1..2^CNT_W).
REQ-004 SHALL have parameter GAP, default 16: cycles between consecutive domain releases (1..2^CNT_W).
REQ-005 SHALL have parameter DEB_CYC, default 8: consecutive synchronised-high cycles needed to accept a button press (1..255).
REQ-006 SHALL have parameter TRAP_RST, default 1: 1 means a CPU trap triggers a reset; 0 means trap is ignored.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-009 SHALL have port btn_rst  input  1  asynchronous external reset button, active-high.
REQ-010 SHALL have port sw_rst_req  input  1  software reset request, one-cycle pulse, active-high.
REQ-011 SHALL have port trap  input  1  CPU trap level, active-high.
REQ-012 SHALL have port dom_rst  output  N_DOM  per-domain reset, active-high; bit 0 is released first.
REQ-013 SHALL have port rst_done  output  1  high when every domain is released.
REQ-014 SHALL have port rst_cause  output  2  cause of the last reset: 00 POR, 01 button, 10 trap, 11 software.

Function
REQ-015 SHALL implement an FSM with states HOLD (all dom_rst high), RELEASE (domains deasserting in order) and RUN (all released).
REQ-016 SHALL pass btn_rst through a 2-FF synchroniser, then a debounce counter that clears on any synchronised-low sample.
REQ-017 SHALL raise btn_trig on every cycle in which the synchronised button has been high for at least DEB_CYC consecutive cycles; btn_trig SHALL stay high while the button is held.
REQ-018 SHALL accept btn_trig in every state; sw_rst_req, and trap when TRAP_RST=1, SHALL be accepted only in RUN.
REQ-019 SHALL, on an accepted trigger in cycle t, drive all dom_rst bits high, clear rst_done, reload the counter and enter HOLD at edge t+1.
REQ-020 SHALL apply cause priority on simultaneous triggers: button over trap over software; rst_cause SHALL update at the same edge as REQ-019.
REQ-021 SHALL keep the FSM in HOLD, with the counter reloaded every cycle, while btn_trig stays high.
REQ-022 SHALL, in HOLD, release dom_rst[0] and enter RELEASE exactly HOLD edges after the last reload.
REQ-023 SHALL, in RELEASE, release dom_rst[k] exactly GAP edges after dom_rst[k-1].
REQ-024 SHALL, at the edge that releases dom_rst[N_DOM-1], raise rst_done and enter RUN; when N_DOM=1 this is the REQ-022 edge.
REQ-025 SHALL abort RELEASE on a trigger arriving mid-sequence: already-released domains reassert per REQ-019 and the sequence restarts from bit 0.
REQ-026 SHALL ensure dom_rst only deasserts in ascending bit order and never glitches; all outputs are registered.
REQ-027 SHALL evaluate the counter's terminal test before decrement so that HOLD=1 and GAP=1 are exact, with no off-by-one.

Reset
REQ-028 SHALL, while rst_n is low at a clock edge, set dom_rst all ones, rst_done 0, rst_cause 00, state HOLD, counter reloaded, synchroniser and debounce cleared.
REQ-029 SHALL take rst_n low mid-sequence or in RUN with priority over all triggers, producing REQ-028 values at the next edge.
REQ-030 SHALL count the first edge sampled with rst_n high as hold edge 1.

Verification (N_DOM=3, HOLD=8, GAP=4, DEB_CYC=3, TRAP_RST=1)
REQ-031 SHALL cover POR: rst_n low 5 cycles then high -> dom_rst=111 until edge 8, 110 at edge 8, 100 at edge 12, 000 and rst_done=1 at edge 16, rst_cause=00.
REQ-032 SHALL cover a software reset: sw_rst_req pulsed in RUN at cycle t -> dom_rst=111 and rst_done=0 at t+1, rst_cause=11, release at t+9, t+13, t+17.
REQ-033 SHALL cover button debounce: 2-cycle btn pulse -> no reset; 10-cycle btn pulse -> reset asserted, rst_cause=01, HOLD counted from btn_trig falling.
REQ-034 SHALL cover an abort: sw_rst_req is ignored during RELEASE; trap in RUN coinciding with sw_rst_req -> rst_cause=10; button press while dom_rst=110 -> dom_rst=111 next edge and sequence restarts.
REQ-035 SHALL cover a mid-sequence POR: rst_n low while dom_rst=100 -> 111, rst_cause=00 next edge; with TRAP_RST=0, trap high in RUN -> no change.
